// File: rtl/famicom_bus_pkg.sv
// Shared types and default timing for the Famicom CPU bus initiator.
package famicom_bus_pkg;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } m2_state_t;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 8;

    localparam int              DEF_M2_LOW_CLKS       = 4;
    localparam int              DEF_M2_HIGH_CLKS      = 4;
    localparam int              DEF_ROMSEL_DELAY_CLKS = 1;
    localparam logic [15:0]     DEF_IDLE_ADDR         = 16'h0000;

endpackage

// File: rtl/famicom_m2_phase_gen.sv
// Free-running M2 phase generator: LOW/HIGH phases, cycle boundary and /ROMSEL strobe.
module famicom_m2_phase_gen
    import famicom_bus_pkg::*;
#(
    parameter int M2_LOW_CLKS       = DEF_M2_LOW_CLKS,
    parameter int M2_HIGH_CLKS      = DEF_M2_HIGH_CLKS,
    parameter int ROMSEL_DELAY_CLKS = DEF_ROMSEL_DELAY_CLKS
) (
    input  logic clk,
    input  logic rst_n,
    output logic m2,
    output logic boundary,
    output logic romsel_strobe
);

    localparam int MAX_CLKS = (M2_LOW_CLKS > M2_HIGH_CLKS) ? M2_LOW_CLKS : M2_HIGH_CLKS;
    localparam int CNT_W    = $clog2(MAX_CLKS);

    m2_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             low_end, high_end;

    assign low_end  = (state == ST_LOW)  && (cnt == CNT_W'(M2_LOW_CLKS - 1));
    assign high_end = (state == ST_HIGH) && (cnt == CNT_W'(M2_HIGH_CLKS - 1));

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        if (low_end) begin
            state_next = ST_HIGH;
            cnt_next   = '0;
        end else if (high_end) begin
            state_next = ST_LOW;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOW;
            cnt   <= '0;
            m2    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            m2    <= (state_next == ST_HIGH);
        end
    end

    assign boundary = high_end;

    // A zero delay means /ROMSEL drops together with the M2 rise.
    assign romsel_strobe = (ROMSEL_DELAY_CLKS == 0) ? low_end
                         : ((state == ST_HIGH) && (cnt == CNT_W'(ROMSEL_DELAY_CLKS - 1)));

endmodule

// File: rtl/famicom_cpu_bus_master.sv
// Host request port to Famicom cartridge CPU bus cycles, with idle reads between requests.
module famicom_cpu_bus_master
    import famicom_bus_pkg::*;
#(
    parameter int          M2_LOW_CLKS       = DEF_M2_LOW_CLKS,
    parameter int          M2_HIGH_CLKS      = DEF_M2_HIGH_CLKS,
    parameter int          ROMSEL_DELAY_CLKS = DEF_ROMSEL_DELAY_CLKS,
    parameter logic [15:0] IDLE_ADDR         = DEF_IDLE_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CPU_ADDR_W-1:0] req_addr,
    input  logic                  req_write,
    input  logic [CPU_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [CPU_DATA_W-1:0] rsp_rdata,
    output logic                  m2,
    output logic                  romsel,
    output logic                  cpu_rw,
    output logic [CPU_ADDR_W-2:0] cpu_addr,
    output logic [CPU_DATA_W-1:0] cpu_data_out,
    output logic                  cpu_data_oe,
    input  logic [CPU_DATA_W-1:0] cpu_data_in,
    input  logic                  irq,
    output logic                  irq_pending
);

    logic boundary;
    logic romsel_strobe;
    logic accept;
    logic busy;
    logic a15;
    logic [1:0] irq_sync;

    famicom_m2_phase_gen #(
        .M2_LOW_CLKS       (M2_LOW_CLKS),
        .M2_HIGH_CLKS      (M2_HIGH_CLKS),
        .ROMSEL_DELAY_CLKS (ROMSEL_DELAY_CLKS)
    ) u_phase_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .m2            (m2),
        .boundary      (boundary),
        .romsel_strobe (romsel_strobe)
    );

    assign req_ready = boundary;
    assign accept    = req_valid && boundary;

    // Everything latched for a cycle changes on the M2 falling edge (the boundary).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            a15          <= 1'b0;
            romsel       <= 1'b1;
            cpu_rw       <= 1'b1;
            cpu_addr     <= '0;
            cpu_data_out <= '0;
            cpu_data_oe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            rsp_valid <= boundary && busy;
            if (boundary) begin
                romsel <= 1'b1;
                if (busy && cpu_rw) begin
                    rsp_rdata <= cpu_data_in;
                end
                if (accept) begin
                    busy         <= 1'b1;
                    a15          <= req_addr[CPU_ADDR_W-1];
                    cpu_addr     <= req_addr[CPU_ADDR_W-2:0];
                    cpu_rw       <= ~req_write;
                    cpu_data_out <= req_wdata;
                    cpu_data_oe  <= req_write;
                end else begin
                    busy        <= 1'b0;
                    a15         <= IDLE_ADDR[CPU_ADDR_W-1];
                    cpu_addr    <= IDLE_ADDR[CPU_ADDR_W-2:0];
                    cpu_rw      <= 1'b1;
                    cpu_data_oe <= 1'b0;
                end
            end else if (romsel_strobe && a15) begin
                romsel <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync <= '0;
        end else begin
            irq_sync <= {irq_sync[0], ~irq};
        end
    end

    assign irq_pending = irq_sync[1];

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// Randomized bench for famicom_cpu_bus_master against a cycle-position reference model.
module tb_famicom_cpu_bus_master;

    localparam int          LOW  = 4;
    localparam int          HIGH = 4;
    localparam int          DLY  = 1;
    localparam int          PER  = LOW + HIGH;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in = '0;
    logic        irq = 1'b1;
    logic        irq_pending;

    logic        din_fixed = 1'b1;
    logic [7:0]  din_value = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    famicom_cpu_bus_master #(
        .M2_LOW_CLKS       (LOW),
        .M2_HIGH_CLKS      (HIGH),
        .ROMSEL_DELAY_CLKS (DLY),
        .IDLE_ADDR         (IDLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .m2           (m2),
        .romsel       (romsel),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_data_in  (cpu_data_in),
        .irq          (irq),
        .irq_pending  (irq_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position inside the bus cycle is the edge count since reset modulo PER.
    int unsigned n_edges = 0;
    logic        m_busy = 1'b0;
    logic        m_write = 1'b0;
    logic [15:0] m_addr = IDLE;
    logic [7:0]  m_data = '0;
    logic        m_rsp = 1'b0;
    logic [7:0]  m_rdata = '0;
    logic        irq_h0 = 1'b0;
    logic        irq_h1 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edges = 0;
            m_busy  = 1'b0;
            m_write = 1'b0;
            m_addr  = IDLE;
            m_rsp   = 1'b0;
            m_rdata = '0;
            irq_h0  = 1'b0;
            irq_h1  = 1'b0;
        end else begin
            m_rsp = 1'b0;
            if ((n_edges % PER) == PER - 1) begin
                if (m_busy) begin
                    m_rsp = 1'b1;
                    if (!m_write) m_rdata = cpu_data_in;
                end
                if (req_valid) begin
                    m_busy  = 1'b1;
                    m_write = req_write;
                    m_addr  = req_addr;
                    m_data  = req_wdata;
                end else begin
                    m_busy  = 1'b0;
                    m_write = 1'b0;
                    m_addr  = IDLE;
                end
            end
            n_edges++;
            irq_h1 = irq_h0;
            irq_h0 = ~irq;
        end
    end

    always @(negedge clk) begin
        int unsigned pos;
        pos = n_edges % PER;
        check("m2",          m2,          pos >= LOW);
        check("romsel",      romsel,      !(m_addr[15] && pos >= LOW + DLY));
        check("cpu_rw",      cpu_rw,      !(m_busy && m_write));
        check("cpu_addr",    cpu_addr,    m_addr[14:0]);
        check("cpu_data_oe", cpu_data_oe, m_busy && m_write);
        if (m_busy && m_write) check("cpu_data_out", cpu_data_out, m_data);
        check("rsp_valid",   rsp_valid,   m_rsp);
        check("rsp_rdata",   rsp_rdata,   m_rdata);
        check("req_ready",   req_ready,   pos == PER - 1);
        check("irq_pending", irq_pending, irq_h1);
        cpu_data_in = din_fixed ? din_value : 8'($urandom);
    end

    task automatic do_req(input logic [15:0] addr, input logic wr, input logic [7:0] wd);
        bit done;
        done      = 1'b0;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 3 * PER && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle cycles after reset
        wait_clks(4 * PER);

        // Read $8123 returning A5
        din_value = 8'hA5;
        do_req(16'h8123, 1'b0, 8'h00);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * PER && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                check("read_a5_data", rsp_rdata, 8'hA5);
            end
        end
        if (!seen) check("read_a5_timeout", 0, 1);

        // Write $6000 = 3C
        do_req(16'h6000, 1'b1, 8'h3C);
        req_valid = 1'b0;
        wait_clks(2 * PER);
        check("write_keeps_rdata", rsp_rdata, 8'hA5);

        // Back-to-back reads with req_valid held high
        din_fixed = 1'b0;
        do_req(16'h8000, 1'b0, 8'h00);
        do_req(16'hC000, 1'b0, 8'h00);
        do_req(16'hE000, 1'b0, 8'h00);
        req_valid = 1'b0;
        wait_clks(2 * PER);

        // Reset asserted at HIGH cnt=2 of a write
        do_req(16'h6001, 1'b1, 8'h5A);
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_m2",     m2,          1'b0);
        check("rst_romsel", romsel,      1'b1);
        check("rst_rw",     cpu_rw,      1'b1);
        check("rst_addr",   cpu_addr,    15'h0);
        check("rst_oe",     cpu_data_oe, 1'b0);
        check("rst_dout",   cpu_data_out, 8'h00);
        check("rst_rsp",    rsp_valid,   1'b0);
        check("rst_rdata",  rsp_rdata,   8'h00);
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(2 * PER);

        // irq assert / release
        @(negedge clk);
        irq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("irq_set", irq_pending, 1'b1);
        @(negedge clk);
        irq = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("irq_clr", irq_pending, 1'b0);

        // Random traffic with random gaps and random irq
        for (int k = 0; k < 40; k++) begin
            wait_clks($urandom_range(0, 2) * PER + $urandom_range(0, 3));
            irq = 1'($urandom);
            do_req(16'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        irq = 1'b1;
        wait_clks(3 * PER);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/famicom_cpu_bus_master.md
Name: famicom_cpu_bus_master

Overview:
- Initiator side of the Famicom cartridge CPU bus. It generates M2, /ROMSEL, R/W, address and write data toward a cartridge slot, and captures read data.
- Used by the dumper/programmer and the test rig to drive the cartridge mapper exactly as a 2A03 would.
- A simple valid/ready request port on the host side is turned into one CPU bus cycle per request.
- When no request is pending, M2 keeps running with idle reads, so cartridge logic that counts M2 edges keeps operating.

Parameters:
- M2_LOW_CLKS, 4, clk periods per cycle with M2 low (minimum 2).
- M2_HIGH_CLKS, 4, clk periods per cycle with M2 high (minimum 2).
- ROMSEL_DELAY_CLKS, 1, clk periods from M2 rise to /ROMSEL fall (must be less than M2_HIGH_CLKS).
- IDLE_ADDR, 16'h0000, address presented on idle cycles.

Ports:
- clk  in  1  system clock. All state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  request accepted this clk when req_valid is also high.
- req_addr  in  16  CPU address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-clk pulse when an accepted cycle completes (read or write).
- rsp_rdata  out  8  captured read data.
- m2  out  1  CPU phase-2 clock to the cartridge.
- romsel  out  1  /ROMSEL, active low.
- cpu_rw  out  1  1 = read, 0 = write.
- cpu_addr  out  15  A14..A0.
- cpu_data_out  out  8  data driven on writes.
- cpu_data_oe  out  1  tristate enable for cpu_data_out.
- cpu_data_in  in  8  bus data for reads.
- irq  in  1  cartridge /IRQ, active low, asynchronous.
- irq_pending  out  1  two-flop synchronized, inverted irq.

Behaviour:
- Reset (asynchronous, immediate):
  - m2=0, romsel=1, cpu_rw=1, cpu_addr=0, cpu_data_out=0, cpu_data_oe=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, irq_pending=0.
  - FSM goes to LOW with cnt=0 and an idle cycle latched.
  - Reset mid-cycle aborts the cycle: no rsp_valid, and the request is never re-issued.
- FSM has two states, LOW and HIGH, with counter cnt:
  - LOW counts 0..M2_LOW_CLKS-1, then moves to HIGH with cnt=0.
  - HIGH counts 0..M2_HIGH_CLKS-1, then moves to LOW with cnt=0 (the cycle boundary).
  - Cycle length is M2_LOW_CLKS+M2_HIGH_CLKS clks. The cycle runs free and never stalls.
- m2 is registered and equals (state==HIGH).
- Acceptance:
  - req_ready is combinational and equals (state==HIGH && cnt==M2_HIGH_CLKS-1); first acceptance is at the end of the first idle cycle after reset.
  - On the boundary edge with req_valid&&req_ready, cpu_addr, cpu_rw (=~req_write), cpu_data_out and a busy flag are loaded.
  - Otherwise idle is loaded: cpu_addr=IDLE_ADDR[14:0], cpu_rw=1, busy=0.
  - Address and R/W change on the same edge that M2 falls.
- romsel:
  - Forced to 1 on the boundary edge.
  - Set to 0 on the edge where state==HIGH and cnt==ROMSEL_DELAY_CLKS-1 (with ROMSEL_DELAY_CLKS=0, on the LOW→HIGH edge), only if latched A15=1.
  - Stays 0 until the next boundary.
- cpu_data_oe is 1 for the whole cycle when a write is latched, and deasserts on the boundary of the next non-write cycle.
- Read capture: on the boundary edge ending a busy read, rsp_rdata <= cpu_data_in, which is the value sampled just before M2 falls.
- rsp_valid:
  - Pulses for exactly one clk after the boundary edge of any busy cycle.
  - For writes, rsp_rdata is unchanged.
  - Idle cycles never produce rsp_valid.
- Back-to-back: a request accepted at every boundary gives one cycle per M2 period with no gap. Completion (rsp_valid) and the next acceptance happen on the same boundary edge.
- irq_pending = ~irq through two flops, a latency of 2 clks. It is level-only, not latched.

Decomposition:
- Package famicom_bus_pkg holds:
  - the state enum (ST_LOW, ST_HIGH);
  - the default timing constants;
  - the address width constants (CPU_ADDR_W=16, CPU_DATA_W=8).
- One sub-module, famicom_m2_phase_gen, contains the state, cnt and m2 register and produces boundary and romsel_strobe.
- The top level holds the latches, the handshake and the irq synchronizer.

Test Plan (default parameters, 8 clk/cycle):
- Reset release, no requests for 4 cycles:
  - m2 has period 8 clk, 50% duty.
  - cpu_addr=0, cpu_rw=1, romsel stays 1, rsp_valid never pulses.
- Read of $8123 with cpu_data_in=8'hA5 during HIGH:
  - cpu_addr=15'h0123 from the boundary.
  - romsel falls 1 clk after m2 rises and rises with m2 fall.
  - rsp_valid pulses once with rsp_rdata=8'hA5.
- Write $6000=8'h3C:
  - cpu_rw=0 and cpu_data_oe=1 for all 8 clks.
  - cpu_data_out=8'h3C, romsel stays 1 (A15=0).
  - rsp_valid pulses once and rsp_rdata is unchanged.
- req_valid held high for 3 reads ($8000, $C000, $E000):
  - Three consecutive cycles with no idle between.
  - Three rsp_valid pulses spaced exactly 8 clk apart.
- rst_n pulled low at HIGH cnt=2 of a write:
  - Outputs reach reset values without waiting for a clk edge.
  - No rsp_valid; the first post-reset cycle is idle.
- irq driven low:
  - irq_pending=1 two clks later.
  - irq released gives irq_pending=0 two clks later.
